// File: rtl/uart_rx.sv
// 8N1 serial receiver sampled once per bit by a bit-rate clock.
// Delivers each well-framed byte with a one-cycle strobe; cts is high only while idle.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock_115200hz,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rts,
  output logic                 cts,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_ready,
  output logic [1:0]           state_dbg
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA      = 2'd1,
    STOP      = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic [DATA_BITS-1:0]   shift_d;
  logic [DATA_BITS-1:0]   data_q;
  logic                   ready_q;
  logic                   cts_q;
  logic                   rx_s;
  logic                   unused_rts;

  // Flow control from the host is accepted but intentionally ignored.
  assign unused_rts = rts;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
  assign shift_d = {rx_s, shift_q[DATA_BITS-1:1]};

  always_ff @(posedge clock_115200hz or negedge reset) begin
    if (!reset) begin
      sync_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      cts_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cts_q <= 1'b1;
          if (!rx_s) begin
            state_q <= DATA;
            cnt_q   <= '0;
            cts_q   <= 1'b0;
          end
        end
        DATA: begin
          shift_q <= shift_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) state_q <= STOP;
        end
        STOP: begin
          if (rx_s) begin
            data_q  <= shift_q;
            ready_q <= 1'b1;
            cts_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            // Framing error or break: drop the byte and wait for the line to recover.
            state_q <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_q <= IDLE;
            cts_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cts           = cts_q;
  assign rx_data       = data_q;
  assign rx_data_ready = ready_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: a frame-level model of the sampled line predicts
// cts / rx_data / rx_data_ready after every clock edge, plus a byte scoreboard.
module tb_uart_rx;

  localparam int SYNC = 2;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       rts;
  logic       cts;
  logic [7:0] rx_data;
  logic       rx_data_ready;
  logic [1:0] state_dbg;

  uart_rx #(.DATA_BITS(8), .SYNC_STAGES(SYNC)) dut (
    .clock_115200hz(clk),
    .reset         (reset),
    .rx            (rx),
    .rts           (rts),
    .cts           (cts),
    .rx_data       (rx_data),
    .rx_data_ready (rx_data_ready),
    .state_dbg     (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Line bits for the current segment: line_q[i] is driven before edge i+1.
  bit         line_q[$];
  logic [7:0] exp_q[$];
  int         strobe_n[$];

  bit         m_cts[];
  bit         m_rdy[];
  logic [7:0] m_byte[];
  logic [7:0] m_data[];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver helpers that build the line waveform
  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) line_q.push_back(1'b1);
  endtask

  task automatic push_low(input int n);
    for (int i = 0; i < n; i++) line_q.push_back(1'b0);
  endtask

  task automatic push_frame(input logic [7:0] b, input bit stop);
    line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) line_q.push_back(b[i]);
    line_q.push_back(stop);
    if (stop) exp_q.push_back(b);
  endtask

  // Line value as seen by the receiver's decision logic at edge n (after the synchronizer delay).
  function automatic bit rxs(input int n);
    int idx;
    idx = n - SYNC - 1;
    if (idx < 0) return 1'b1;
    if (idx >= line_q.size()) return line_q[line_q.size()-1];
    return line_q[idx];
  endfunction

  // Frame-level reference: walk the sampled line, find start bits, decode bytes.
  task automatic build_model(input int nn);
    int pos;
    int e;
    int m;
    logic [7:0] b;
    logic [7:0] cur;
    m_cts  = new[nn + 1];
    m_rdy  = new[nn + 1];
    m_byte = new[nn + 1];
    m_data = new[nn + 1];
    for (int n = 0; n <= nn; n++) begin
      m_cts[n] = 1'b1;
      m_rdy[n] = 1'b0;
      m_byte[n] = 8'h00;
    end
    pos = 1;
    while (pos <= nn) begin
      if (rxs(pos)) begin
        pos++;
      end else begin
        b = 8'h00;
        for (int i = 0; i < 8; i++) b[i] = rxs(pos + 1 + i);
        for (int k = pos; k <= pos + 8; k++) if (k <= nn) m_cts[k] = 1'b0;
        e = pos + 9;
        if (e > nn) break;
        if (rxs(e)) begin
          m_rdy[e]  = 1'b1;
          m_byte[e] = b;
          pos = e + 1;
        end else begin
          m_cts[e] = 1'b0;
          m = e + 1;
          while (m <= nn && !rxs(m)) begin
            m_cts[m] = 1'b0;
            m++;
          end
          pos = m + 1;
        end
      end
    end
    cur = 8'h00;
    for (int n = 1; n <= nn; n++) begin
      if (m_rdy[n]) cur = m_byte[n];
      m_data[n] = cur;
    end
  endtask

  // Reset, release, then compare every cycle against the model and scoreboard.
  task automatic run_segment(input int seg);
    int nn;
    nn = line_q.size();
    build_model(nn);
    @(negedge clk);
    reset = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    chk($sformatf("seg%0d reset cts", seg), 32'(cts), 32'd0);
    chk($sformatf("seg%0d reset rdy", seg), 32'(rx_data_ready), 32'd0);
    chk($sformatf("seg%0d reset data", seg), 32'(rx_data), 32'h00);
    strobe_n.delete();
    reset = 1'b1;
    rx    = line_q[0];
    rts   = 1'($urandom_range(0, 1));
    for (int n = 1; n <= nn; n++) begin
      @(negedge clk);
      chk($sformatf("seg%0d cts@%0d", seg, n), 32'(cts), 32'(m_cts[n]));
      chk($sformatf("seg%0d rdy@%0d", seg, n), 32'(rx_data_ready), 32'(m_rdy[n]));
      chk($sformatf("seg%0d data@%0d", seg, n), 32'(rx_data), 32'(m_data[n]));
      if (rx_data_ready === 1'b1) begin
        strobe_n.push_back(n);
        if (exp_q.size() == 0) chk($sformatf("seg%0d extra strobe@%0d", seg, n), 32'd1, 32'd0);
        else chk($sformatf("seg%0d sb byte@%0d", seg, n), 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (seg == 1 && n == 1)  chk("cts first edge", 32'(cts), 32'd1);
      if (seg == 1 && n == 23) chk("cts low at start detect", 32'(cts), 32'd0);
      if (seg == 1 && n == 32) chk("cts high at strobe", 32'(cts), 32'd1);
      if (n < nn) rx = line_q[n];
      rts = 1'($urandom_range(0, 1));
    end
    chk($sformatf("seg%0d frames missing", seg), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] rb;
    int seg1_gap;
    reset = 1'b0;
    rx    = 1'b1;
    rts   = 1'b0;

    // Segment 1: idle, 0x62, back-to-back 0x55/0xA3, broken 0xFF, 0x00, 0x81, random traffic.
    line_q.delete();
    push_idle(20);
    push_frame(8'h62, 1'b1);
    push_idle(5);
    push_frame(8'h55, 1'b1);
    push_frame(8'hA3, 1'b1);
    push_idle(3);
    push_frame(8'hFF, 1'b0);
    push_low(5);
    push_idle(4);
    push_frame(8'h00, 1'b1);
    push_idle(3);
    push_frame(8'h81, 1'b1);
    push_idle(2);
    for (int f = 0; f < 14; f++) begin
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) begin
        push_frame(rb, 1'b0);
        push_low($urandom_range(0, 3));
        push_idle(1 + $urandom_range(0, 2));
      end else begin
        push_frame(rb, 1'b1);
        push_idle($urandom_range(0, 3));
      end
    end
    push_idle(15);
    run_segment(1);
    chk("first strobe edge", 32'(strobe_n.size() > 0 ? strobe_n[0] : -1), 32'd32);
    seg1_gap = (strobe_n.size() >= 3) ? strobe_n[2] - strobe_n[1] : -1;
    chk("back-to-back spacing", 32'(seg1_gap), 32'd10);

    // Segment 2: a good frame, then a frame cut off by reset after data bit 4.
    line_q.delete();
    push_idle(3);
    push_frame(8'hE7, 1'b1);
    push_idle(2);
    line_q.push_back(1'b0);
    line_q.push_back(1'b0);
    line_q.push_back(1'b1);
    line_q.push_back(1'b1);
    line_q.push_back(1'b0);
    line_q.push_back(1'b1);
    run_segment(2);
    chk("pre-abort byte", 32'(rx_data), 32'hE7);

    // Segment 3: reset clears everything, then 0x3C arrives cleanly.
    line_q.delete();
    push_idle(3);
    push_frame(8'h3C, 1'b1);
    push_idle(15);
    run_segment(3);
    chk("post-reset strobes", 32'(strobe_n.size()), 32'd1);
    chk("post-reset byte", 32'(rx_data), 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
